// File: rtl/bus_model_pkg.sv
// Shared types and constants for the top8227 bus memory responder.
package bus_model_pkg;

   // First byte of each little-endian vector pair at the top of the address map.
   localparam logic [15:0] NMI_VEC_ADDR   = 16'hFFFA;
   localparam logic [15:0] RESET_VEC_ADDR = 16'hFFFC;
   localparam logic [15:0] IRQ_VEC_ADDR   = 16'hFFFE;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      ASSERT = 2'd2
   } chan_state_t;

   typedef struct packed {
      logic [15:0] trig;
      logic [7:0]  len;
      logic        nmi;
   } chan_cfg_t;

   // True for the six vector bytes FFFA..FFFF, which are read-only.
   function automatic logic is_vector_addr(input logic [15:0] addr);
      return (addr >= NMI_VEC_ADDR);
   endfunction

endpackage

// File: rtl/bus_mem_responder_int_channel.sv
// One cycle-scheduled interrupt channel: waits for a retire count, then
// holds its line active for max(len,1) clocks and raises a sticky done flag.
module int_channel
   import bus_model_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_we,
   input  chan_cfg_t   cfg_in,
   input  logic [15:0] cycle_count,
   input  logic        count_new,
   output logic        line_active,
   output logic        line_nmi,
   output logic        done
);

   chan_state_t state_q, state_d;
   chan_cfg_t   cfg_q, cfg_d;
   logic [7:0]  len_cnt_q, len_cnt_d;
   logic        done_q, done_d;

   // Channel state, latched configuration, remaining length and done flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cfg_q     <= '0;
         len_cnt_q <= 8'd0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cfg_q     <= cfg_d;
         len_cnt_q <= len_cnt_d;
         done_q    <= done_d;
      end
   end

   // Next state: programming always wins; a match only counts on the clock
   // right after the retire that produced it, so a trig equal to the count at
   // programming time waits for the counter to come round again.
   always_comb begin
      state_d   = state_q;
      cfg_d     = cfg_q;
      len_cnt_d = len_cnt_q;
      done_d    = done_q;
      if (cfg_we) begin
         state_d   = ARMED;
         cfg_d     = cfg_in;
         len_cnt_d = 8'd0;
         done_d    = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            ARMED: begin
               if (count_new && (cycle_count == cfg_q.trig)) begin
                  state_d   = ASSERT;
                  len_cnt_d = (cfg_q.len == 8'd0) ? 8'd1 : cfg_q.len;
               end else begin
                  state_d = ARMED;
               end
            end
            ASSERT: begin
               if (len_cnt_q <= 8'd1) begin
                  state_d   = IDLE;
                  len_cnt_d = 8'd0;
                  done_d    = 1'b1;
               end else begin
                  len_cnt_d = len_cnt_q - 8'd1;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   assign line_active = (state_q == ASSERT);
   assign line_nmi    = cfg_q.nmi;
   assign done        = done_q;

endmodule

// File: rtl/bus_mem_responder.sv
// Memory, vector and interrupt responder sitting on the top8227 bus pins.
module bus_mem_responder
   import bus_model_pkg::*;
#(
   parameter int          DEPTH_W   = 12,
   parameter int          WAIT_RD   = 0,
   parameter int          WAIT_WR   = 0,
   parameter logic [15:0] NMI_VEC   = 16'hAA00,
   parameter logic [15:0] RESET_VEC = 16'hCCF0,
   parameter logic [15:0] IRQ_VEC   = 16'hBB00,
   parameter int          INT_CH    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        addressBusHigh,
   input  logic [7:0]        addressBusLow,
   input  logic [7:0]        dataBusOutput,
   input  logic              readNotWrite,
   output logic [7:0]        dataBusInput,
   output logic              ready,
   output logic              nonMaskableInterrupt,
   output logic              interruptRequest,
   input  logic              loadEn,
   input  logic [15:0]       loadAddr,
   input  logic [7:0]        loadData,
   input  logic              cfgWe,
   input  logic [2:0]        cfgCh,
   input  logic [15:0]       cfgTrig,
   input  logic [7:0]        cfgLen,
   input  logic              cfgNmi,
   output logic [INT_CH-1:0] intDone,
   output logic [15:0]       cycleCount
);

   localparam int         DEPTH     = 2 ** DEPTH_W;
   localparam logic [3:0] WAIT_RD_C = 4'(WAIT_RD);
   localparam logic [3:0] WAIT_WR_C = 4'(WAIT_WR);

   logic [15:0]        addr_s;
   logic [DEPTH_W-1:0] core_idx_s;
   logic [DEPTH_W-1:0] load_idx_s;
   logic               load_addr_unused_s;
   logic [3:0]         target_s;
   logic               retire_s;
   logic               core_we_s;
   logic [7:0]         rd_data_s;

   logic [3:0]  wait_cnt_q, wait_cnt_d;
   logic [15:0] cycle_count_q, cycle_count_d;
   logic        count_new_q, count_new_d;

   // Backing store; deliberately has no reset so contents survive rst.
   logic [7:0] mem_array [DEPTH];

   assign addr_s             = {addressBusHigh, addressBusLow};
   assign core_idx_s         = addr_s[DEPTH_W-1:0];
   assign load_idx_s         = loadAddr[DEPTH_W-1:0];
   assign load_addr_unused_s = ^loadAddr;

   assign target_s  = readNotWrite ? WAIT_RD_C : WAIT_WR_C;
   assign retire_s  = (wait_cnt_q == target_s);
   assign ready     = retire_s;
   assign core_we_s = retire_s & ~readNotWrite & ~is_vector_addr(addr_s) & ~rst;

   // Wait counter wraps through 15 if the target drops below it mid-cycle.
   always_comb begin
      wait_cnt_d    = wait_cnt_q;
      cycle_count_d = cycle_count_q;
      count_new_d   = 1'b0;
      if (retire_s) begin
         wait_cnt_d    = 4'd0;
         cycle_count_d = cycle_count_q + 16'd1;
         count_new_d   = 1'b1;
      end else begin
         wait_cnt_d = wait_cnt_q + 4'd1;
      end
   end

   // Bus-cycle bookkeeping: wait count, retire count and the retire pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt_q    <= 4'd0;
         cycle_count_q <= 16'd0;
         count_new_q   <= 1'b0;
      end else begin
         wait_cnt_q    <= wait_cnt_d;
         cycle_count_q <= cycle_count_d;
         count_new_q   <= count_new_d;
      end
   end

   // RAM writes; the preload is issued last so it wins a same-byte collision.
   always_ff @(posedge clk) begin
      if (core_we_s) begin
         mem_array[core_idx_s] <= dataBusOutput;
      end
      if (loadEn) begin
         mem_array[load_idx_s] <= loadData;
      end
   end

   // Combinational read path with the vector bytes overlaid at the top.
   always_comb begin
      rd_data_s = mem_array[core_idx_s];
      case (addr_s)
         NMI_VEC_ADDR:           rd_data_s = NMI_VEC[7:0];
         NMI_VEC_ADDR + 16'd1:   rd_data_s = NMI_VEC[15:8];
         RESET_VEC_ADDR:         rd_data_s = RESET_VEC[7:0];
         RESET_VEC_ADDR + 16'd1: rd_data_s = RESET_VEC[15:8];
         IRQ_VEC_ADDR:           rd_data_s = IRQ_VEC[7:0];
         IRQ_VEC_ADDR + 16'd1:   rd_data_s = IRQ_VEC[15:8];
         default:                rd_data_s = mem_array[core_idx_s];
      endcase
   end

   assign dataBusInput = rd_data_s;
   assign cycleCount   = cycle_count_q;

   chan_cfg_t         cfg_s;
   logic [INT_CH-1:0] ch_active_s;
   logic [INT_CH-1:0] ch_nmi_s;
   logic [INT_CH-1:0] ch_done_s;

   assign cfg_s = '{trig: cfgTrig, len: cfgLen, nmi: cfgNmi};

   // Channel selects beyond INT_CH match no instance and are thus ignored.
   for (genvar i = 0; i < INT_CH; i++) begin : g_chan
      int_channel u_chan (
         .clk         (clk),
         .rst         (rst),
         .cfg_we      (cfgWe && (cfgCh == 3'(i))),
         .cfg_in      (cfg_s),
         .cycle_count (cycle_count_q),
         .count_new   (count_new_q),
         .line_active (ch_active_s[i]),
         .line_nmi    (ch_nmi_s[i]),
         .done        (ch_done_s[i])
      );
   end

   // Active-low lines: any asserting channel of the matching kind pulls low.
   assign nonMaskableInterrupt = ~|(ch_active_s & ch_nmi_s);
   assign interruptRequest     = ~|(ch_active_s & ~ch_nmi_s);
   assign intDone              = ch_done_s;

endmodule
